// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Registered issue stage that sits in front of the EX-stage barrel shifter.
// It receives decoded R-type shift instructions from ID through a valid/ready
// handshake. Each instruction is decoded into a 2-bit shifter control code and
// a 5-bit shift amount, taken either from the immediate shamt field or from
// rs[4:0]. The decoded entry is then held in a 2-entry skid buffer (main + skid)
// so that in_ready toward ID is a flop output and never a combinational
// function of out_ready.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous flush, drops every held entry
//   in_valid     ID presents an instruction
//   in_ready     stage can accept (registered, equals !skid_full)
//   in_funct     funct field
//   in_shamt     immediate shift amount
//   in_rs        rs operand (low 5 bits = variable shift amount)
//   in_rt        rt operand (value to shift)
//   in_rd        destination register tag
//   out_valid    shifter operands valid
//   out_ready    downstream consumes the shifter result this cycle
//   sh_in        shifter data input
//   sh_shamt     shifter shift amount
//   sh_ctrl      shifter control: 00 SLL, 01 SRA, 10 SRL, 11 unused (yields 0)
//   out_rd       destination register tag
//   out_illegal  funct was not a shift opcode
// -----------------------------------------------------------------------------
module shift_issue_stage #(
   parameter int DATA_W  = 32,
   parameter int FUNCT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FUNCT_W-1:0] in_funct,
   input  logic [4:0]         in_shamt,
   input  logic [DATA_W-1:0]  in_rs,
   input  logic [DATA_W-1:0]  in_rt,
   input  logic [4:0]         in_rd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  sh_in,
   output logic [4:0]         sh_shamt,
   output logic [1:0]         sh_ctrl,
   output logic [4:0]         out_rd,
   output logic               out_illegal
);

   localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
   localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
   localparam logic [FUNCT_W-1:0] F_SRA  = FUNCT_W'(6'b000011);
   localparam logic [FUNCT_W-1:0] F_SLLV = FUNCT_W'(6'b000100);
   localparam logic [FUNCT_W-1:0] F_SRLV = FUNCT_W'(6'b000110);
   localparam logic [FUNCT_W-1:0] F_SRAV = FUNCT_W'(6'b000111);

   localparam logic [1:0] CTRL_SLL = 2'b00;
   localparam logic [1:0] CTRL_SRA = 2'b01;
   localparam logic [1:0] CTRL_SRL = 2'b10;
   localparam logic [1:0] CTRL_NOP = 2'b11;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [4:0]        shamt;
      logic [1:0]        ctrl;
      logic [4:0]        rd;
      logic              illegal;
   } entry_t;

   // EMPTY: nothing held; ONE: main full; TWO: main and skid full.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_t;

   state_t state_q;
   logic   out_valid_q;
   logic   in_ready_q;
   entry_t main_q;
   entry_t skid_q;
   entry_t dec_s;

   // Decode funct into shifter control and pick the shift amount source.
   always_comb begin
      dec_s.data    = in_rt;
      dec_s.rd      = in_rd;
      dec_s.shamt   = 5'd0;
      dec_s.ctrl    = CTRL_NOP;
      dec_s.illegal = 1'b0;
      case (in_funct)
         F_SLL: begin
            dec_s.ctrl  = CTRL_SLL;
            dec_s.shamt = in_shamt;
         end
         F_SRA: begin
            dec_s.ctrl  = CTRL_SRA;
            dec_s.shamt = in_shamt;
         end
         F_SRL: begin
            dec_s.ctrl  = CTRL_SRL;
            dec_s.shamt = in_shamt;
         end
         F_SLLV: begin
            dec_s.ctrl  = CTRL_SLL;
            dec_s.shamt = in_rs[4:0];
         end
         F_SRAV: begin
            dec_s.ctrl  = CTRL_SRA;
            dec_s.shamt = in_rs[4:0];
         end
         F_SRLV: begin
            dec_s.ctrl  = CTRL_SRL;
            dec_s.shamt = in_rs[4:0];
         end
         default: begin
            // Unknown opcode still flows through; the shifter yields 0 on ctrl 11.
            dec_s.ctrl    = CTRL_NOP;
            dec_s.shamt   = 5'd0;
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   // Skid-buffer FSM with registered handshake outputs and data registers.
   // In EMPTY and ONE in_ready_q is 1, so in_valid alone means an accept there;
   // in TWO in_ready_q is 0 and nothing is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_q      <= '{data: '0, shamt: 5'd0, ctrl: CTRL_NOP, rd: 5'd0, illegal: 1'b0};
         skid_q      <= '{data: '0, shamt: 5'd0, ctrl: CTRL_NOP, rd: 5'd0, illegal: 1'b0};
      end else if (flush) begin
         // Drop everything; data registers keep their contents.
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  main_q      <= dec_s;
                  state_q     <= ST_ONE;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
               end
            end
            ST_ONE: begin
               if (in_valid && out_ready) begin
                  main_q <= dec_s;
               end else if (in_valid) begin
                  skid_q     <= dec_s;
                  state_q    <= ST_TWO;
                  in_ready_q <= 1'b0;
               end else if (out_ready) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_TWO: begin
               if (out_ready) begin
                  main_q     <= skid_q;
                  state_q    <= ST_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign sh_in       = main_q.data;
   assign sh_shamt    = main_q.shamt;
   assign sh_ctrl     = main_q.ctrl;
   assign out_rd      = main_q.rd;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Directed, table-driven bench for shift_issue_stage. Each table row is one
// clock cycle: inputs driven at the falling edge, outputs compared 1 ns after
// the following rising edge. Mid-cycle reset is covered by a hand-written
// sequence after the table.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_funct;
   logic [4:0]  in_shamt;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sh_in;
   logic [4:0]  sh_shamt;
   logic [1:0]  sh_ctrl;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_checks;
   int n_pass;

   shift_issue_stage #(.DATA_W(32), .FUNCT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_funct    (in_funct),
      .in_shamt    (in_shamt),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sh_in       (sh_in),
      .sh_shamt    (sh_shamt),
      .sh_ctrl     (sh_ctrl),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  rd;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_in;
      logic [4:0]  e_shamt;
      logic [1:0]  e_ctrl;
      logic [4:0]  e_rd;
      logic        e_ill;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   // Compare all observable outputs against an expected bundle.
   task automatic check(input string name, input logic e_ov, input logic e_ir,
                        input logic [31:0] e_in, input logic [4:0] e_shamt,
                        input logic [1:0] e_ctrl, input logic [4:0] e_rd,
                        input logic e_ill);
      logic [46:0] act;
      logic [46:0] exp;
      act = {out_valid, in_ready, sh_in, sh_shamt, sh_ctrl, out_rd, out_illegal};
      exp = {e_ov, e_ir, e_in, e_shamt, e_ctrl, e_rd, e_ill};
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got ov=%b ir=%b in=%h shamt=%0d ctrl=%b rd=%0d ill=%b, want ov=%b ir=%b in=%h shamt=%0d ctrl=%b rd=%0d ill=%b",
                  name, out_valid, in_ready, sh_in, sh_shamt, sh_ctrl, out_rd, out_illegal,
                  e_ov, e_ir, e_in, e_shamt, e_ctrl, e_rd, e_ill);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid  = v.vld;
      in_funct  = v.funct;
      in_shamt  = v.shamt;
      in_rs     = v.rs;
      in_rt     = v.rt;
      in_rd     = v.rd;
      out_ready = v.ordy;
      flush     = v.fl;
   endtask

   // One table row: drive at negedge, sample 1 ns after the next posedge.
   task automatic apply(input string name, input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      check(name, v.e_ov, v.e_ir, v.e_in, v.e_shamt, v.e_ctrl, v.e_rd, v.e_ill);
   endtask

   initial begin
      vec_t idle;
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_funct  = 6'd0;
      in_shamt  = 5'd0;
      in_rs     = 32'd0;
      in_rt     = 32'd0;
      in_rd     = 5'd0;
      out_ready = 1'b0;

      //          vld   funct  shamt  rs            rt            rd     ordy  fl    ov    ir    sh_in         shamt  ctrl   rd     ill
      // Decode coverage, streaming with out_ready=1.
      vecs[0]  = '{1'b1, 6'h00, 5'd4,  32'h0,        32'h00000001, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 32'h00000001, 5'd4,  2'b00, 5'd5,  1'b0}; // SLL
      vecs[1]  = '{1'b1, 6'h07, 5'd9,  32'hFFFFFFE3, 32'h80000000, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 32'h80000000, 5'd3,  2'b01, 5'd6,  1'b0}; // SRAV
      vecs[2]  = '{1'b1, 6'h02, 5'd31, 32'h0,        32'hDEADBEEF, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd31, 2'b10, 5'd7,  1'b0}; // SRL
      vecs[3]  = '{1'b1, 6'h04, 5'd5,  32'h00000020, 32'h12345678, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 5'd0,  2'b00, 5'd8,  1'b0}; // SLLV
      vecs[4]  = '{1'b1, 6'h06, 5'd2,  32'hFFFFFFFF, 32'hA5A5A5A5, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 5'd31, 2'b10, 5'd9,  1'b0}; // SRLV
      vecs[5]  = '{1'b1, 6'h03, 5'd1,  32'h0,        32'h80000001, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80000001, 5'd1,  2'b01, 5'd10, 1'b0}; // SRA
      vecs[6]  = '{1'b1, 6'h20, 5'd7,  32'h3,        32'hCAFEF00D, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 5'd0,  2'b11, 5'd11, 1'b1}; // illegal
      vecs[7]  = '{1'b0, 6'h00, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 5'd0,  2'b11, 5'd11, 1'b1}; // drain
      vecs[8]  = '{1'b0, 6'h00, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 5'd0,  2'b11, 5'd11, 1'b1}; // idle hold
      // Back-pressure: A, B, C with out_ready=0, then release.
      vecs[9]  = '{1'b1, 6'h00, 5'd1,  32'h0,        32'h0000000A, 5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0000000A, 5'd1,  2'b00, 5'd1,  1'b0}; // A in
      vecs[10] = '{1'b1, 6'h02, 5'd2,  32'h0,        32'h0000000B, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000000A, 5'd1,  2'b00, 5'd1,  1'b0}; // B -> skid
      vecs[11] = '{1'b1, 6'h03, 5'd3,  32'h0,        32'h0000000C, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000000A, 5'd1,  2'b00, 5'd1,  1'b0}; // C held
      vecs[12] = '{1'b1, 6'h03, 5'd3,  32'h0,        32'h0000000C, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000B, 5'd2,  2'b10, 5'd2,  1'b0}; // B out
      vecs[13] = '{1'b1, 6'h03, 5'd3,  32'h0,        32'h0000000C, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000C, 5'd3,  2'b01, 5'd3,  1'b0}; // C out
      vecs[14] = '{1'b0, 6'h00, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000000C, 5'd3,  2'b01, 5'd3,  1'b0}; // drain
      // Flush in TWO with in_valid=1.
      vecs[15] = '{1'b1, 6'h00, 5'd4,  32'h0,        32'h0000000D, 5'd4,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0000000D, 5'd4,  2'b00, 5'd4,  1'b0}; // D in
      vecs[16] = '{1'b1, 6'h02, 5'd5,  32'h0,        32'h0000000E, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000000D, 5'd4,  2'b00, 5'd4,  1'b0}; // E -> skid
      vecs[17] = '{1'b1, 6'h04, 5'd0,  32'h6,        32'h0000000F, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000000D, 5'd4,  2'b00, 5'd4,  1'b0}; // flush + F
      vecs[18] = '{1'b1, 6'h03, 5'd6,  32'h0,        32'h00000010, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000010, 5'd6,  2'b01, 5'd14, 1'b0}; // G first
      vecs[19] = '{1'b0, 6'h00, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h00000010, 5'd6,  2'b01, 5'd14, 1'b0}; // drain

      // Reset values while rst is held.
      #3;
      check("reset", 1'b0, 1'b1, 32'h0, 5'd0, 2'b11, 5'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Fill to TWO, then pulse rst between clock edges.
      apply("pre_rst_A", '{1'b1, 6'h00, 5'd2, 32'h0, 32'h11111111, 5'd20, 1'b0, 1'b0,
                           1'b1, 1'b1, 32'h11111111, 5'd2, 2'b00, 5'd20, 1'b0});
      apply("pre_rst_B", '{1'b1, 6'h02, 5'd3, 32'h0, 32'h22222222, 5'd21, 1'b0, 1'b0,
                           1'b1, 1'b0, 32'h11111111, 5'd2, 2'b00, 5'd20, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 1'b0, 1'b1, 32'h0, 5'd0, 2'b11, 5'd0, 1'b0);
      #1;
      rst = 1'b0;
      // Skid entry B must be gone: an idle cycle leaves the stage empty.
      idle = '{1'b0, 6'h00, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0,
               1'b0, 1'b1, 32'h0, 5'd0, 2'b11, 5'd0, 1'b0};
      apply("post_rst_idle", idle);
      apply("post_rst_accept", '{1'b1, 6'h06, 5'd0, 32'h00000045, 32'h33333333, 5'd22, 1'b1, 1'b0,
                                 1'b1, 1'b1, 32'h33333333, 5'd5, 2'b10, 5'd22, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
